// File: rtl/mac_ctrl_pkg.sv
// Shared types and defaults for the MAC-array pass sequencer.
package mac_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CLR       = 3'd1,
        ST_WAIT_FULL = 3'd2,
        ST_RUN       = 3'd3,
        ST_DRAIN     = 3'd4,
        ST_DONE      = 3'd5
    } mac_ctrl_state_t;

    localparam int DEF_ROWS      = 8;
    localparam int DEF_DEPTH     = 8;
    localparam int DEF_SKEW      = 1;
    localparam int DEF_DRAIN_CYC = 2;

    // Cycles from the first read of row 0 to the last read of the last row.
    function automatic int mac_run_len(input int rows, input int depth, input int skew);
        return (rows - 1) * skew + depth;
    endfunction

endpackage

// File: rtl/mac_array_ctrl_skew_gen.sv
// Pure decode of the run counter into skewed per-row A reads and the B read.
module mac_skew_gen
    import mac_ctrl_pkg::*;
#(
    parameter int ROWS  = DEF_ROWS,
    parameter int DEPTH = DEF_DEPTH,
    parameter int SKEW  = DEF_SKEW,
    parameter int TW    = 4
) (
    input  logic            run_i,
    input  logic [TW-1:0]   t_i,
    output logic [ROWS-1:0] a_ren_o,
    output logic            b_ren_o
);

    logic [31:0] t_ext_s;

    // Row r reads during the DEPTH-cycle window starting at r*SKEW.
    always_comb begin
        t_ext_s = 32'(t_i);
        a_ren_o = '0;
        b_ren_o = 1'b0;
        if (run_i) begin
            b_ren_o = (t_ext_s < 32'(DEPTH));
            for (int r = 0; r < ROWS; r++) begin
                a_ren_o[r] = (t_ext_s >= 32'(r * SKEW)) && (t_ext_s < 32'(r * SKEW + DEPTH));
            end
        end else begin
            a_ren_o = '0;
            b_ren_o = 1'b0;
        end
    end

endmodule

// File: rtl/mac_array_ctrl.sv
// Pass sequencer for a row of accumulating MACs: clear, wait for full FIFOs,
// issue skewed reads, drain the pipeline, then pulse done.
module mac_array_ctrl
    import mac_ctrl_pkg::*;
#(
    parameter int ROWS      = DEF_ROWS,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int SKEW      = DEF_SKEW,
    parameter int DRAIN_CYC = DEF_DRAIN_CYC
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic [ROWS-1:0] a_full,
    input  logic            b_full,
    output logic [ROWS-1:0] a_ren,
    output logic            b_ren,
    output logic            mac_clr,
    output logic            mac_en0,
    output logic            busy,
    output logic            done
);

    localparam int RUN_LEN = mac_run_len(ROWS, DEPTH, SKEW);
    // The same counter times DRAIN, so size it for whichever phase is longer.
    localparam int T_MAX = (RUN_LEN > DRAIN_CYC) ? RUN_LEN : DRAIN_CYC;
    localparam int TW    = $clog2(T_MAX + 1);
    localparam logic [TW-1:0] T_ZERO       = TW'(0);
    localparam logic [TW-1:0] T_ONE        = TW'(1);
    localparam logic [TW-1:0] T_RUN_LAST   = TW'(RUN_LEN - 1);
    localparam logic [TW-1:0] T_DRAIN_LAST = TW'(DRAIN_CYC - 1);

    mac_ctrl_state_t state_q, state_d;
    logic [TW-1:0]   t_q, t_d;
    logic            mac_en0_q, mac_en0_d;
    logic            run_s;
    logic            b_ren_s;
    logic [ROWS-1:0] a_ren_s;

    mac_skew_gen #(
        .ROWS  (ROWS),
        .DEPTH (DEPTH),
        .SKEW  (SKEW),
        .TW    (TW)
    ) u_skew (
        .run_i   (run_s),
        .t_i     (t_q),
        .a_ren_o (a_ren_s),
        .b_ren_o (b_ren_s)
    );

    // State, counter and head-of-chain enable registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            t_q       <= T_ZERO;
            mac_en0_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            t_q       <= t_d;
            mac_en0_q <= mac_en0_d;
        end
    end

    // Next-state and counter logic; abort overrides every transition.
    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        if (abort) begin
            state_d = ST_IDLE;
            t_d     = T_ZERO;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    t_d = T_ZERO;
                    if (start) begin
                        state_d = ST_CLR;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_CLR: begin
                    state_d = ST_WAIT_FULL;
                    t_d     = T_ZERO;
                end
                ST_WAIT_FULL: begin
                    t_d = T_ZERO;
                    if ((&a_full) && b_full) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_WAIT_FULL;
                    end
                end
                ST_RUN: begin
                    if (t_q == T_RUN_LAST) begin
                        state_d = ST_DRAIN;
                        t_d     = T_ZERO;
                    end else begin
                        t_d = t_q + T_ONE;
                    end
                end
                ST_DRAIN: begin
                    if (t_q == T_DRAIN_LAST) begin
                        state_d = ST_DONE;
                        t_d     = T_ZERO;
                    end else begin
                        t_d = t_q + T_ONE;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                    t_d     = T_ZERO;
                end
                default: begin
                    state_d = ST_IDLE;
                    t_d     = T_ZERO;
                end
            endcase
        end
    end

    // mac_en0 trails b_ren by the one-cycle FIFO read latency; abort kills it.
    always_comb begin
        if (abort) begin
            mac_en0_d = 1'b0;
        end else begin
            mac_en0_d = b_ren_s;
        end
    end

    // Output decode from registered state only.
    always_comb begin
        run_s   = 1'b0;
        mac_clr = 1'b0;
        busy    = 1'b1;
        done    = 1'b0;
        case (state_q)
            ST_IDLE:      busy    = 1'b0;
            ST_CLR:       mac_clr = 1'b1;
            ST_WAIT_FULL: run_s   = 1'b0;
            ST_RUN:       run_s   = 1'b1;
            ST_DRAIN:     run_s   = 1'b0;
            ST_DONE:      done    = 1'b1;
            default:      busy    = 1'b0;
        endcase
    end

    assign a_ren   = a_ren_s;
    assign b_ren   = b_ren_s;
    assign mac_en0 = mac_en0_q;

endmodule

// File: tb/tb_mac_array_ctrl.sv
// Directed, table-driven bench for mac_array_ctrl (default and swept parameters).
module tb_mac_array_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       b_full = 1'b1;
    logic [7:0] a_full = 8'hFF;
    logic [7:0] a_ren;
    logic       b_ren, mac_clr, mac_en0, busy, done;

    logic       start4 = 1'b0;
    logic       abort4 = 1'b0;
    logic       b_full4 = 1'b1;
    logic [3:0] a_full4 = 4'hF;
    logic [3:0] a_ren4;
    logic       b_ren4, mac_clr4, mac_en0_4, busy4, done4;

    logic [12:0] obs;
    assign obs = {mac_clr, b_ren, a_ren, mac_en0, busy, done};

    always #5 clk = ~clk;

    mac_array_ctrl u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .a_full(a_full), .b_full(b_full), .a_ren(a_ren), .b_ren(b_ren),
        .mac_clr(mac_clr), .mac_en0(mac_en0), .busy(busy), .done(done)
    );

    mac_array_ctrl #(.ROWS(4), .DEPTH(16), .SKEW(2), .DRAIN_CYC(2)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .abort(abort4),
        .a_full(a_full4), .b_full(b_full4), .a_ren(a_ren4), .b_ren(b_ren4),
        .mac_clr(mac_clr4), .mac_en0(mac_en0_4), .busy(busy4), .done(done4)
    );

    typedef struct {
        logic        start;
        logic        abort;
        logic [7:0]  a_full;
        logic [12:0] exp;
    } vec_t;

    vec_t vecs[64];
    int   checks = 0;
    int   errors = 0;

    // Expected {mac_clr,b_ren,a_ren[7:0],mac_en0,busy,done} in cycle c for a pass
    // whose start was sampled at edge s and whose RUN begins in cycle rs.
    function automatic logic [12:0] exp8(input int c, input int s, input int rs);
        logic [7:0] a;
        logic clr, b, en, bz, dn;
        for (int r = 0; r < 8; r++) a[r] = (c >= rs + r) && (c < rs + r + 8);
        clr = (c == s + 1);
        b   = (c >= rs) && (c < rs + 8);
        en  = (c >= rs + 1) && (c < rs + 9);
        bz  = (c > s) && (c <= rs + 17);
        dn  = (c == rs + 17);
        return {clr, b, a, en, bz, dn};
    endfunction

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", name, got, exp);
        end
    endtask

    task automatic clear_vecs();
        for (int c = 0; c < 64; c++) begin
            vecs[c].start  = 1'b0;
            vecs[c].abort  = 1'b0;
            vecs[c].a_full = 8'hFF;
            vecs[c].exp    = 13'h0;
        end
    endtask

    // vecs[c] inputs are held during cycle c (sampled at edge c); outputs checked in cycle c.
    task automatic apply_table(input string name, input int n);
        @(negedge clk);
        start  = vecs[0].start;
        abort  = vecs[0].abort;
        a_full = vecs[0].a_full;
        for (int c = 1; c <= n; c++) begin
            @(posedge clk);
            #1;
            start  = vecs[c].start;
            abort  = vecs[c].abort;
            a_full = vecs[c].a_full;
            @(negedge clk);
            checks++;
            if (obs !== vecs[c].exp) begin
                errors++;
                $display("FAIL %s cycle %0d got %b exp %b", name, c, obs, vecs[c].exp);
            end
        end
        start  = 1'b0;
        abort  = 1'b0;
        a_full = 8'hFF;
    endtask

    int cnt4[4];
    int first4[4];
    int done_cnt, done_cyc, busy_cnt, bren_cnt, bren_first, clr_cyc;

    initial begin
        #2 rst_n = 1'b0;
        #10;
        check("reset_outputs", int'(obs), 0);
        check("reset_outputs4", int'({mac_clr4, b_ren4, a_ren4, mac_en0_4, busy4, done4}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_after_reset", int'(obs), 0);

        // Nominal pass.
        clear_vecs();
        vecs[0].start = 1'b1;
        for (int c = 1; c <= 24; c++) vecs[c].exp = exp8(c, 0, 3);
        apply_table("nominal", 24);

        // Start while busy must be ignored.
        clear_vecs();
        vecs[0].start = 1'b1;
        vecs[8].start = 1'b1;
        for (int c = 1; c <= 30; c++) vecs[c].exp = exp8(c, 0, 3);
        apply_table("start_busy", 30);

        // A-row 7 not full until cycle 11.
        clear_vecs();
        vecs[0].start = 1'b1;
        for (int c = 0; c <= 10; c++) vecs[c].a_full = 8'h7F;
        for (int c = 1; c <= 35; c++) vecs[c].exp = exp8(c, 0, 12);
        apply_table("fill_wait", 35);

        // Abort at RUN t=5, start+abort together in IDLE, then a fresh pass.
        clear_vecs();
        vecs[0].start  = 1'b1;
        vecs[8].abort  = 1'b1;
        vecs[10].start = 1'b1;
        vecs[10].abort = 1'b1;
        vecs[12].start = 1'b1;
        for (int c = 1; c <= 34; c++) vecs[c].exp = (c <= 8) ? exp8(c, 0, 3) : exp8(c, 12, 15);
        apply_table("abort", 34);

        // Asynchronous reset during DRAIN.
        @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= 18; c++) begin
            @(posedge clk);
            #1 start = 1'b0;
            @(negedge clk);
        end
        check("in_drain_busy", int'(busy), 1);
        check("in_drain_nodone", int'(done), 0);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_outputs", int'(obs), 0);
        @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        busy_cnt = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (done) done_cnt++;
            if (busy) busy_cnt++;
        end
        check("async_rst_no_done", done_cnt, 0);
        check("async_rst_idle", busy_cnt, 0);

        // Parameter sweep instance: ROWS=4, DEPTH=16, SKEW=2.
        for (int r = 0; r < 4; r++) begin
            cnt4[r]   = 0;
            first4[r] = -1;
        end
        done_cnt = 0; done_cyc = -1; busy_cnt = 0;
        bren_cnt = 0; bren_first = -1; clr_cyc = -1;
        @(negedge clk);
        start4 = 1'b1;
        for (int c = 1; c <= 34; c++) begin
            @(posedge clk);
            #1 start4 = 1'b0;
            @(negedge clk);
            for (int r = 0; r < 4; r++) begin
                if (a_ren4[r]) begin
                    cnt4[r]++;
                    if (first4[r] < 0) first4[r] = c;
                end
            end
            if (b_ren4) begin
                bren_cnt++;
                if (bren_first < 0) bren_first = c;
            end
            if (mac_clr4) clr_cyc = c;
            if (done4) begin
                done_cnt++;
                done_cyc = c;
            end
            if (busy4) busy_cnt++;
        end
        for (int r = 0; r < 4; r++) begin
            check($sformatf("sweep_aren%0d_len", r), cnt4[r], 16);
            check($sformatf("sweep_aren%0d_first", r), first4[r], 3 + 2 * r);
        end
        check("sweep_bren_len", bren_cnt, 16);
        check("sweep_bren_first", bren_first, 3);
        check("sweep_clr_cycle", clr_cyc, 1);
        check("sweep_done_cycle", done_cyc, 27);
        check("sweep_done_count", done_cnt, 1);
        check("sweep_busy_cycles", busy_cnt, 27);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
